// File: rtl/inst_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, bubble encoding, immediate formats
// and the decoded-instruction bundle carried through the ID/EX register.
package inst_decode_pkg;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_ALU_IMM = 7'b0010011;
  localparam logic [6:0] OP_ALU_REG = 7'b0110011;
  localparam logic [6:0] OP_SYSTEM  = 7'b1110011;

  localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;

  typedef enum logic [2:0] {
    IMM_R,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        is_load;
    logic        is_store;
    logic        is_branch;
    logic        is_jal;
    logic        is_jalr;
    logic        is_lui;
    logic        is_auipc;
    logic        is_alu_imm;
    logic        is_alu_reg;
    logic        is_system;
    logic        illegal;
    logic        reg_we;
  } dec_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_type_e t);
    logic [31:0] imm;
    imm = '0;
    case (t)
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/inst_decode_dec.sv
// rv32i_dec: purely combinational RV32I field/immediate/class decode.
// Zero latency; no flow control (pure function of inst).
module rv32i_dec
  import inst_decode_pkg::*;
(
  input  logic [31:0] inst,
  output dec_t        dec,
  output logic        uses_rs1,
  output logic        uses_rs2
);

  imm_type_e itype;

  always_comb begin
    dec        = '0;
    itype      = IMM_R;
    uses_rs1   = 1'b0;
    uses_rs2   = 1'b0;
    dec.rd     = inst[11:7];
    dec.rs1    = inst[19:15];
    dec.rs2    = inst[24:20];
    dec.funct3 = inst[14:12];
    dec.funct7 = inst[31:25];
    case (inst[6:0])
      OP_LOAD:    begin dec.is_load    = 1'b1; uses_rs1 = 1'b1; itype = IMM_I; end
      OP_STORE:   begin dec.is_store   = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; itype = IMM_S; end
      OP_BRANCH:  begin dec.is_branch  = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; itype = IMM_B; end
      OP_JAL:     begin dec.is_jal     = 1'b1; itype = IMM_J; end
      OP_JALR:    begin dec.is_jalr    = 1'b1; uses_rs1 = 1'b1; itype = IMM_I; end
      OP_LUI:     begin dec.is_lui     = 1'b1; itype = IMM_U; end
      OP_AUIPC:   begin dec.is_auipc   = 1'b1; itype = IMM_U; end
      OP_ALU_IMM: begin dec.is_alu_imm = 1'b1; uses_rs1 = 1'b1; itype = IMM_I; end
      OP_ALU_REG: begin dec.is_alu_reg = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1; end
      OP_SYSTEM:  begin dec.is_system  = 1'b1; itype = IMM_I; end
      default:    dec.illegal = 1'b1;
    endcase
    dec.imm = gen_imm(inst, itype);
    // Only classes that produce a result write rd, and x0 is never written.
    dec.reg_we = (dec.rd != 5'd0) &
                 (dec.is_load | dec.is_jal | dec.is_jalr | dec.is_lui |
                  dec.is_auipc | dec.is_alu_imm | dec.is_alu_reg);
  end

endmodule

// File: rtl/inst_decode.sv
// ID stage: decodes fetch output into the ID/EX register (1-cycle latency).
// Load-use hazard holds fetch one cycle and inserts a bubble; an EX jump squashes.
module inst_decode #(
  parameter logic [31:0] NOP_INST = inst_decode_pkg::NOP_INST_DEF,
  parameter bit          PERF_EN  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_inst,
  input  logic        jmp_vld,
  output logic        hold_IF,
  output logic        id_vld,
  output logic [31:0] id_pc,
  output logic [31:0] id_inst,
  output logic [4:0]  id_rd,
  output logic [4:0]  id_rs1,
  output logic [4:0]  id_rs2,
  output logic [2:0]  id_funct3,
  output logic [6:0]  id_funct7,
  output logic [31:0] id_imm,
  output logic        id_is_load,
  output logic        id_is_store,
  output logic        id_is_branch,
  output logic        id_is_jal,
  output logic        id_is_jalr,
  output logic        id_is_lui,
  output logic        id_is_auipc,
  output logic        id_is_alu_imm,
  output logic        id_is_alu_reg,
  output logic        id_is_system,
  output logic        id_illegal,
  output logic        id_reg_we,
  output logic [31:0] perf_dec_cnt,
  output logic [31:0] perf_stall_cnt
);
  import inst_decode_pkg::*;

  dec_t dec;
  dec_t id_q;
  logic uses_rs1;
  logic uses_rs2;
  logic hazard;

  rv32i_dec u_dec (
    .inst     (if_inst),
    .dec      (dec),
    .uses_rs1 (uses_rs1),
    .uses_rs2 (uses_rs2)
  );

  // The load sits in the ID/EX register; the consumer is the word fetch presents now.
  assign hazard = id_vld & id_q.is_load & (id_q.rd != 5'd0) &
                  ((uses_rs1 & (dec.rs1 == id_q.rd)) | (uses_rs2 & (dec.rs2 == id_q.rd)));

  assign hold_IF = ~rst & ~jmp_vld & hazard;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_vld         <= 1'b0;
      id_pc          <= '0;
      id_inst        <= NOP_INST;
      id_q           <= '0;
      perf_dec_cnt   <= '0;
      perf_stall_cnt <= '0;
    end else if (jmp_vld || hazard) begin
      id_vld  <= 1'b0;
      id_pc   <= if_pc;
      id_inst <= NOP_INST;
      id_q    <= '0;
      if (PERF_EN && !jmp_vld) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end else begin
      id_vld  <= 1'b1;
      id_pc   <= if_pc;
      id_inst <= if_inst;
      id_q    <= dec;
      if (PERF_EN) perf_dec_cnt <= perf_dec_cnt + 32'd1;
    end
  end

  assign id_rd         = id_q.rd;
  assign id_rs1        = id_q.rs1;
  assign id_rs2        = id_q.rs2;
  assign id_funct3     = id_q.funct3;
  assign id_funct7     = id_q.funct7;
  assign id_imm        = id_q.imm;
  assign id_is_load    = id_q.is_load;
  assign id_is_store   = id_q.is_store;
  assign id_is_branch  = id_q.is_branch;
  assign id_is_jal     = id_q.is_jal;
  assign id_is_jalr    = id_q.is_jalr;
  assign id_is_lui     = id_q.is_lui;
  assign id_is_auipc   = id_q.is_auipc;
  assign id_is_alu_imm = id_q.is_alu_imm;
  assign id_is_alu_reg = id_q.is_alu_reg;
  assign id_is_system  = id_q.is_system;
  assign id_illegal    = id_q.illegal;
  assign id_reg_we     = id_q.reg_we;

endmodule

// File: tb/tb_inst_decode.sv
// Bench for inst_decode: directed steps plus random instruction streams
// checked against an instruction-level reference model.
module tb_inst_decode;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, jmp_vld, hold_IF, id_vld;
  logic [31:0] if_pc, if_inst, id_pc, id_inst, id_imm, perf_dec_cnt, perf_stall_cnt;
  logic [4:0]  id_rd, id_rs1, id_rs2;
  logic [2:0]  id_funct3;
  logic [6:0]  id_funct7;
  logic id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr, id_is_lui;
  logic id_is_auipc, id_is_alu_imm, id_is_alu_reg, id_is_system, id_illegal, id_reg_we;
  logic [9:0] dut_flags;

  inst_decode dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .if_inst(if_inst), .jmp_vld(jmp_vld),
    .hold_IF(hold_IF), .id_vld(id_vld), .id_pc(id_pc), .id_inst(id_inst),
    .id_rd(id_rd), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct3(id_funct3),
    .id_funct7(id_funct7), .id_imm(id_imm), .id_is_load(id_is_load),
    .id_is_store(id_is_store), .id_is_branch(id_is_branch), .id_is_jal(id_is_jal),
    .id_is_jalr(id_is_jalr), .id_is_lui(id_is_lui), .id_is_auipc(id_is_auipc),
    .id_is_alu_imm(id_is_alu_imm), .id_is_alu_reg(id_is_alu_reg),
    .id_is_system(id_is_system), .id_illegal(id_illegal), .id_reg_we(id_reg_we),
    .perf_dec_cnt(perf_dec_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  assign dut_flags = {id_is_system, id_is_alu_reg, id_is_alu_imm, id_is_auipc, id_is_lui,
                      id_is_jalr, id_is_jal, id_is_branch, id_is_store, id_is_load};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: what the ID/EX register should hold.
  logic        m_vld;
  logic [31:0] m_pc, m_inst, m_dec, m_stall;
  logic        m_pc_chk;

  // Class index: 0 load,1 store,2 branch,3 jal,4 jalr,5 lui,6 auipc,7 alu_imm,8 alu_reg,9 system; -1 illegal
  function automatic int cls_of(logic [31:0] inst);
    case (inst[6:0])
      7'b0000011: return 0;
      7'b0100011: return 1;
      7'b1100011: return 2;
      7'b1101111: return 3;
      7'b1100111: return 4;
      7'b0110111: return 5;
      7'b0010111: return 6;
      7'b0010011: return 7;
      7'b0110011: return 8;
      7'b1110011: return 9;
      default:    return -1;
    endcase
  endfunction

  function automatic bit m_uses1(logic [31:0] inst);
    int c = cls_of(inst);
    return c == 0 || c == 1 || c == 2 || c == 4 || c == 7 || c == 8;
  endfunction

  function automatic bit m_uses2(logic [31:0] inst);
    int c = cls_of(inst);
    return c == 1 || c == 2 || c == 8;
  endfunction

  function automatic logic [31:0] m_imm(logic [31:0] inst);
    int c = cls_of(inst);
    int v;
    v = 0;
    case (c)
      0, 4, 7, 9: v = $signed(inst) >>> 20;
      1: v = (($signed(inst) >>> 25) * 32) + int'(inst[11:7]);
      2: v = (inst[31] ? -4096 : 0) + int'(inst[7]) * 2048 + int'(inst[30:25]) * 32 + int'(inst[11:8]) * 2;
      3: v = (inst[31] ? -(1 << 20) : 0) + int'(inst[19:12]) * 4096 + int'(inst[20]) * 2048 + int'(inst[30:21]) * 2;
      5, 6: v = int'(inst & 32'hFFFF_F000);
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  function automatic bit m_hazard(logic [31:0] nxt);
    logic [4:0] rd;
    rd = m_inst[11:7];
    return m_vld && cls_of(m_inst) == 0 && rd != 5'd0 &&
           ((m_uses1(nxt) && nxt[19:15] == rd) || (m_uses2(nxt) && nxt[24:20] == rd));
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    int c;
    logic [9:0] ef;
    logic we;
    c  = cls_of(m_inst);
    ef = (m_vld && c >= 0) ? 10'(1 << c) : 10'd0;
    we = m_vld && c >= 0 && c != 1 && c != 2 && c != 9 && m_inst[11:7] != 5'd0;
    chk("id_vld", {31'd0, id_vld}, {31'd0, m_vld});
    chk("id_inst", id_inst, m_inst);
    if (m_pc_chk) chk("id_pc", id_pc, m_pc);
    chk("flags", {22'd0, dut_flags}, {22'd0, ef});
    chk("illegal", {31'd0, id_illegal}, {31'd0, m_vld && c < 0});
    chk("reg_we", {31'd0, id_reg_we}, {31'd0, we});
    if (m_vld) begin
      chk("rd", {27'd0, id_rd}, {27'd0, m_inst[11:7]});
      chk("rs1", {27'd0, id_rs1}, {27'd0, m_inst[19:15]});
      chk("rs2", {27'd0, id_rs2}, {27'd0, m_inst[24:20]});
      chk("funct3", {29'd0, id_funct3}, {29'd0, m_inst[14:12]});
      chk("funct7", {25'd0, id_funct7}, {25'd0, m_inst[31:25]});
      if (c >= 0) chk("imm", id_imm, m_imm(m_inst));
    end
    chk("dec_cnt", perf_dec_cnt, m_dec);
    chk("stall_cnt", perf_stall_cnt, m_stall);
  endtask

  // Entered 1 time unit after a rising edge; leaves at the same phase.
  task automatic step(input logic [31:0] pc, input logic [31:0] inst, input logic jmp);
    bit hz;
    if_pc   = pc;
    if_inst = inst;
    jmp_vld = jmp;
    hz = m_hazard(inst);
    #3;
    chk("hold_IF", {31'd0, hold_IF}, {31'd0, !jmp && hz});
    @(posedge clk);
    #1;
    m_pc     = pc;
    m_pc_chk = jmp || !hz;
    if (jmp || hz) begin
      m_vld  = 1'b0;
      m_inst = NOP;
      if (!jmp) m_stall = m_stall + 32'd1;
    end else begin
      m_vld  = 1'b1;
      m_inst = inst;
      m_dec  = m_dec + 32'd1;
    end
    jmp_vld = 1'b0;
    check_outputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_vld = 1'b0; m_pc = '0; m_inst = NOP; m_dec = '0; m_stall = '0; m_pc_chk = 1'b1;
    chk("rst_hold_IF", {31'd0, hold_IF}, 32'd0);
    check_outputs();
    @(posedge clk);
    #1;
    check_outputs();
    rst = 1'b0;
  endtask

  logic [6:0] ops [12];
  logic [31:0] r;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
            7'b0010111, 7'b0010011, 7'b0110011, 7'b1110011, 7'b0001111, 7'b1111111};
    rst = 1'b1; if_pc = '0; if_inst = NOP; jmp_vld = 1'b0;
    @(posedge clk);
    #1;
    do_reset();

    step(32'h10, 32'hFFF00093, 1'b0);
    chk("addi_alu_imm", {31'd0, id_is_alu_imm}, 32'd1);
    chk("addi_rd", {27'd0, id_rd}, 32'd1);
    chk("addi_imm", id_imm, 32'hFFFF_FFFF);
    chk("addi_we", {31'd0, id_reg_we}, 32'd1);
    chk("addi_pc", id_pc, 32'h10);

    step(32'h14, 32'hFE000EE3, 1'b0);
    chk("beq_branch", {31'd0, id_is_branch}, 32'd1);
    chk("beq_imm", id_imm, 32'hFFFF_FFFC);
    chk("beq_we", {31'd0, id_reg_we}, 32'd0);

    do_reset();
    step(32'h20, 32'h0000A103, 1'b0);
    step(32'h24, 32'h00210193, 1'b0);
    chk("lu_bubble", {31'd0, id_vld}, 32'd0);
    step(32'h24, 32'h00210193, 1'b0);
    chk("lu_issue", {31'd0, id_vld}, 32'd1);
    chk("lu_stalls", perf_stall_cnt, 32'd1);
    chk("lu_decs", perf_dec_cnt, 32'd2);

    step(32'h28, 32'h0000A103, 1'b0);
    step(32'h2C, 32'h00210193, 1'b1);
    chk("flush_stalls", perf_stall_cnt, 32'd1);
    chk("flush_vld", {31'd0, id_vld}, 32'd0);

    step(32'h30, 32'h0000000F, 1'b0);
    chk("fence_illegal", {31'd0, id_illegal}, 32'd1);
    chk("fence_vld", {31'd0, id_vld}, 32'd1);
    step(32'h34, 32'h00002003, 1'b0);
    step(32'h38, 32'h00000193, 1'b0);
    chk("x0_no_stall", perf_stall_cnt, 32'd1);
    step(32'h3C, NOP, 1'b0);
    chk("nop_vld", {31'd0, id_vld}, 32'd1);
    chk("nop_we", {31'd0, id_reg_we}, 32'd0);

    // Reset arriving while fetch is being held.
    step(32'h40, 32'h0000A103, 1'b0);
    if_inst = 32'h00210193;
    #1;
    chk("pre_rst_hold", {31'd0, hold_IF}, 32'd1);
    do_reset();

    for (int i = 0; i < 400; i++) begin
      r = $urandom;
      r[6:0]   = ops[$urandom_range(0, 11)];
      r[11:7]  = 5'($urandom_range(0, 3));
      r[19:15] = 5'($urandom_range(0, 3));
      r[24:20] = 5'($urandom_range(0, 3));
      step(32'h1000 + 32'(i * 4), r, $urandom_range(0, 7) == 0);
      if (i == 200) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/inst_decode.md
Name: inst_decode

Overview:
- ID stage of the RV32I core, directly downstream of instruction fetch.
- Captures the fetched pc/inst into the IF/ID→EX pipeline register and decodes RV32I fields, immediates and class flags.
- Detects load-use hazards and asserts a one-cycle fetch hold.
- Squashes the in-flight fetch on a taken jump from EX, and keeps decode/stall performance counters.

Parameters:
- NOP_INST, 32'h00000013, encoding used for inserted bubbles (addi x0,x0,0).
- PERF_EN, 1, 1 = performance counters active; 0 = counters tied to 0.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- if_pc  in  32  pc of instruction presented by fetch
- if_inst  in  32  instruction presented by fetch (already NOP-substituted by fetch)
- jmp_vld  in  1  taken jump/branch resolved in EX this cycle
- hold_IF  out  1  combinational; fetch keeps pc next cycle
- id_vld  out  1  registered; 1 = id_* fields carry a real instruction
- id_pc  out  32  registered pc
- id_inst  out  32  registered raw instruction (NOP_INST when bubble)
- id_rd, id_rs1, id_rs2  out  5 each  register indices
- id_funct3  out  3  inst[14:12]
- id_funct7  out  7  inst[31:25]
- id_imm  out  32  sign-extended immediate
- id_is_load, id_is_store, id_is_branch, id_is_jal, id_is_jalr, id_is_lui, id_is_auipc, id_is_alu_imm, id_is_alu_reg, id_is_system  out  1 each  one-hot class flags
- id_illegal  out  1  opcode not in RV32I base set
- id_reg_we  out  1  writes rd (0 if rd==x0 or illegal/store/branch/system)
- perf_dec_cnt  out  32  instructions issued with id_vld=1
- perf_stall_cnt  out  32  load-use bubbles inserted

Behaviour:
- Reset (async, immediate): all id_* outputs 0, except id_inst = NOP_INST; id_vld=0; both counters 0. hold_IF=0 while rst=1.
- Decode is combinational on if_inst; the result is registered at posedge clk, giving 1-cycle latency IF→EX.
- Immediates:
  - I: sext(inst[31:20]).
  - S: sext({inst[31:25],inst[11:7]}).
  - B: sext({inst[31],inst[7],inst[30:25],inst[11:8],1'b0}).
  - U: {inst[31:12],12'b0}.
  - J: sext({inst[31],inst[19:12],inst[20],inst[30:21],1'b0}).
  - R-type: 0.
- Opcodes: 0000011 load, 0100011 store, 1100011 branch, 1101111 jal, 1100111 jalr, 0110111 lui, 0010111 auipc, 0010011 alu_imm, 0110011 alu_reg, 1110011 system. Anything else (incl. 0001111 fence) sets illegal=1, all class flags 0, reg_we=0, id_vld=1.
- Rs-use:
  - rs1 is used by jalr, load, store, branch, alu_imm and alu_reg.
  - rs2 is used by store, branch and alu_reg.
- Load-use hazard (combinational): id_vld & id_is_load & id_rd!=0 & ((uses_rs1 & rs1==id_rd) | (uses_rs2 & rs2==id_rd)).
- Priority each cycle: rst > jmp_vld > hazard > normal.
  - jmp_vld=1: register a bubble (id_vld=0, id_inst=NOP_INST, flags/reg_we 0, id_pc=if_pc). hold_IF=0, no stall counted.
  - hazard=1 and jmp_vld=0: hold_IF=1; register a bubble; perf_stall_cnt+1. The next cycle the bubble clears the hazard, so a stall never lasts more than one cycle per load.
  - normal: register the decoded instruction, id_vld=1, perf_dec_cnt+1.
- A bubble never counts in perf_dec_cnt. Counters wrap modulo 2^32.
- An if_inst equal to NOP_INST is a real instruction: id_vld=1, alu_imm, reg_we=0 (rd=x0).
- Reset asserted mid-stall: outputs return to reset values immediately; no residual hold_IF.

Decomposition:
- Shared package/defines file: the RV32I opcode constants, NOP_INST, and the imm-type encoding (I/S/B/U/J/R).
- One natural sub-module: rv32i_dec, purely combinational (inst → fields, imm, flags, uses_rs1/uses_rs2, illegal).
- The top holds the pipeline register, hazard/flush logic and counters.

Test Plan:
- Reset: assert rst mid-run → id_vld=0, id_inst=32'h00000013, hold_IF=0, perf counters=0, without waiting for a clock edge.
- Decode: if_inst=32'hFFF00093 (addi x1,x0,-1), pc=0x10 → next cycle id_is_alu_imm=1, id_rd=1, id_imm=32'hFFFFFFFF, id_reg_we=1, id_pc=0x10.
- Branch imm: if_inst=32'hFE000EE3 (beq x0,x0,-4) → id_is_branch=1, id_imm=32'hFFFFFFFC, id_reg_we=0.
- Load-use:
  - Stimulus: 32'h0000A103 (lw x2,0(x1)), then 32'h00210193 (addi x3,x2,2).
  - Cycle 2: hold_IF=1, bubble registered.
  - Cycle 3: addi decodes with id_vld=1.
  - perf_stall_cnt=1, perf_dec_cnt=2.
- Flush beats hazard: same lw/addi pair but jmp_vld=1 in the hazard cycle → hold_IF=0, bubble registered, perf_stall_cnt unchanged.
- Illegal/x0: if_inst=32'h0000000F → id_illegal=1, id_vld=1, id_reg_we=0. lw x0 followed by a user of x0 → no stall.
